// File: rtl/ro_sensor_scheduler.sv
// Run sequencer for a ring-oscillator sensor array: clear, timed enable window,
// settle, then a serial sum of every sensor count through a single adder.
module ro_sensor_scheduler #(
  parameter int NUM_SENSOR = 20,
  parameter int WIDTH      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE     = 4,
  localparam int SEL_W     = $clog2(NUM_SENSOR),
  localparam int SUM_W     = WIDTH + $clog2(NUM_SENSOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             sensor_en,
  output logic             sensor_clr,
  output logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] freq_in,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CNT_W = $clog2(TMAX + 1);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_CLEAR  | one-cycle sensor counter clear, sum zeroed
  // S_MEAS   | sensors enabled for WINDOW cycles
  // S_SETTLE | sensors disabled, counts stabilising for SETTLE cycles
  // S_ACCUM  | one sensor per cycle added into sum
  // S_DONE   | sum presented until accepted
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MEAS, S_SETTLE, S_ACCUM, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    sensor_en  = 1'b0;
    sensor_clr = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        sensor_clr = 1'b1;
        sum_d      = '0;
        tmr_d      = CNT_W'(WINDOW - 1);
        state_d    = S_MEAS;
      end
      S_MEAS: begin
        sensor_en = 1'b1;
        if (tmr_q == '0) begin
          tmr_d   = CNT_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          idx_d   = '0;
          state_d = S_ACCUM;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      S_ACCUM: begin
        sum_d = sum_q + SUM_W'(freq_in);
        if (idx_q == SEL_W'(NUM_SENSOR - 1)) state_d = S_DONE;
        else idx_d = idx_q + SEL_W'(1);
      end
      S_DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) state_d = continuous ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort outranks everything, including a same-cycle handshake in DONE
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sum_d   = sum_q;
    end
  end

  assign sel  = (state_q == S_ACCUM) ? idx_q : '0;
  assign sum  = sum_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ro_sensor_scheduler.sv
// Directed + randomized bench for ro_sensor_scheduler; expectations come from
// the run timeline arithmetic and a plain sum over the modelled sensor counts.
module tb_ro_sensor_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int WIN = 8;
  localparam int ST  = 2;
  localparam int LAT = WIN + ST + N + 2;
  localparam int ACC0 = WIN + ST + 2;

  logic        clk = 1'b0;
  logic        rst, start, continuous, abort, sum_ready;
  logic        sensor_en, sensor_clr, sum_valid, busy;
  logic [1:0]  sel;
  logic [7:0]  freq_in;
  logic [9:0]  sum;
  logic [7:0]  counts [N];

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int last_sum = 0;
  bit poke_start = 1'b0;

  ro_sensor_scheduler #(.NUM_SENSOR(N), .WIDTH(W), .WINDOW(WIN), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .sensor_en(sensor_en), .sensor_clr(sensor_clr), .sel(sel), .freq_in(freq_in),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  assign freq_in = counts[sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_counts(output int s);
    s = 0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       counts[i] = 8'((i + 1) * 10);
        2:       counts[i] = 8'd255;
        default: counts[i] = 8'($urandom_range(0, 255));
      endcase
      s += int'(counts[i]);
    end
  endtask

  // Cycle 0 (start sampled, or previous handshake) must already be in progress.
  task automatic do_run(input int delay, input bit cont);
    int exp_sum;
    int exp_sel;
    exp_sum = 0;
    for (int c = 1; c <= LAT + delay; c++) begin
      step();
      start      = poke_start && (c == 4 || c == WIN + 2);
      sum_ready  = (c >= LAT + delay);
      continuous = (c >= LAT + delay) ? cont : 1'b0;
      if (c == 1) fill_counts(exp_sum);
      exp_sel = (c >= ACC0 && c < ACC0 + N) ? c - ACC0 : 0;
      chk("sensor_clr", 32'(sensor_clr), 32'(c == 1));
      chk("sensor_en", 32'(sensor_en), 32'(c >= 2 && c <= WIN + 1));
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("sum_valid", 32'(sum_valid), 32'(c >= LAT));
      chk("busy", 32'(busy), 32'd1);
      if (c == 2) chk("sum_cleared", 32'(sum), 32'd0);
      if (c >= LAT) chk("sum", 32'(sum), 32'(exp_sum));
    end
    last_sum = exp_sum;
  endtask

  task automatic finish_idle();
    step();
    start = 1'b0; sum_ready = 1'b0; continuous = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(sum_valid), 32'd0);
    chk("idle_en", 32'(sensor_en), 32'd0);
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_sum_hold", 32'(sum), 32'(last_sum));
  endtask

  initial begin
    int dummy;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; sum_ready = 1'b0;
    for (int i = 0; i < N; i++) counts[i] = '0;
    step(); step();
    chk("rst_en", 32'(sensor_en), 32'd0);
    chk("rst_clr", 32'(sensor_clr), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_valid", 32'(sum_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // fixed counts, then saturated counts, then a held-off consumer
    mode = 1; start = 1'b1; do_run(0, 1'b0); finish_idle();
    mode = 2; start = 1'b1; do_run(0, 1'b0); finish_idle();
    mode = 1; start = 1'b1; do_run(5, 1'b0); finish_idle();

    // back-to-back continuous runs, loop ended by dropping continuous
    mode = 0; start = 1'b1;
    do_run(0, 1'b1); do_run(1, 1'b1); do_run(0, 1'b0); finish_idle();

    for (int r = 0; r < 4; r++) begin
      start = 1'b1; do_run(int'($urandom_range(0, 3)), 1'b0); finish_idle();
    end

    // start pulses mid-run must not queue a second run
    poke_start = 1'b1; start = 1'b1; do_run(0, 1'b0); finish_idle(); poke_start = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      step();
      chk("no_queued_run", 32'(busy | sum_valid), 32'd0);
    end

    // abort during MEASURE
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step(); start = 1'b0;
      if (c == 5) abort = 1'b1;
    end
    step(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'(sensor_en), 32'd0);
    chk("abort_valid", 32'(sum_valid), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      chk("abort_no_result", 32'(busy | sum_valid), 32'd0);
    end

    // abort beats a same-cycle handshake in DONE
    start = 1'b1; fill_counts(dummy);
    for (int c = 1; c <= LAT; c++) begin
      step(); start = 1'b0;
    end
    chk("done_reached", 32'(sum_valid), 32'd1);
    abort = 1'b1; sum_ready = 1'b1; continuous = 1'b1;
    step(); abort = 1'b0; sum_ready = 1'b0; continuous = 1'b0;
    chk("abort_done_busy", 32'(busy), 32'd0);
    chk("abort_done_clr", 32'(sensor_clr), 32'd0);
    chk("abort_done_valid", 32'(sum_valid), 32'd0);

    // abort in IDLE blocks a same-cycle start
    abort = 1'b1; start = 1'b1;
    step(); abort = 1'b0; start = 1'b0;
    chk("abort_idle_start", 32'(busy), 32'd0);
    step();
    chk("abort_idle_start2", 32'(busy | sensor_clr), 32'd0);

    // reset during ACCUM
    mode = 1; fill_counts(dummy); start = 1'b1;
    for (int c = 1; c <= ACC0 + 1; c++) begin
      step(); start = 1'b0;
    end
    chk("accum_sel", 32'(sel), 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("midrst_en", 32'(sensor_en), 32'd0);
    chk("midrst_clr", 32'(sensor_clr), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_valid", 32'(sum_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // reset wins over start
    rst = 1'b1; start = 1'b1;
    step(); rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    step();
    chk("rst_start_busy2", 32'(busy | sensor_clr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
